// File: rtl/condlogic_it.sv
// condlogic_it: condition unit with grouped NZCV flags, a delayed flag-write
// pipe and an If-Then predication sequencer that overrides Cond for the
// instructions inside an IT block.
module condlogic_it #(
  parameter int FLAG_GROUPS = 2,
  parameter int FLAGW_DELAY = 1,
  parameter int MAX_IT      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               Cond,
  input  logic [3:0]               ALUFlags,
  input  logic [FLAG_GROUPS-1:0]   FlagW,
  input  logic                     PCS,
  input  logic                     NextPC,
  input  logic                     RegW,
  input  logic                     MemW,
  input  logic                     ITStart,
  input  logic [3:0]               ITCond,
  input  logic [$clog2(MAX_IT):0]  ITLen,
  input  logic [MAX_IT-1:0]        ITMask,
  input  logic                     InstrDone,
  output logic                     PCWrite,
  output logic                     RegWrite,
  output logic                     MemWrite,
  output logic                     CondEx,
  output logic [3:0]               Flags,
  output logic                     ITActive
);

  localparam int LENW = $clog2(MAX_IT) + 1;
  localparam int GW   = 4 / FLAG_GROUPS;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]             state;
  logic [3:0]             itcond_q;
  logic [MAX_IT-1:0]      itmask_q;
  logic [LENW-1:0]        itlen_q;
  logic [LENW-1:0]        it_idx;
  logic [MAX_IT-1:0]      mask_sh;
  logic [3:0]             eff_cond;
  logic                   it_start_ok;
  logic [FLAG_GROUPS-1:0] flagw_req;
  logic [FLAG_GROUPS-1:0] flag_load;

  // ARM condition-code evaluation on {N,Z,C,V}; 1111 treated as always.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = ~cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cf & ~z;
      4'b1001: cond_pass = ~cf | z;
      4'b1010: cond_pass = ~(n ^ v);
      4'b1011: cond_pass = n ^ v;
      4'b1100: cond_pass = ~z & ~(n ^ v);
      4'b1101: cond_pass = z | (n ^ v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  // Select the condition in force: the decoder's Cond, or the IT slot's then/else condition.
  always_comb begin
    mask_sh  = itmask_q >> it_idx;
    eff_cond = Cond;
    if (state == ACTIVE) begin
      eff_cond = mask_sh[0] ? itcond_q : (itcond_q ^ 4'b0001);
    end
  end

  assign CondEx    = cond_pass(eff_cond, Flags);
  assign PCWrite   = (PCS & CondEx) | NextPC;
  assign RegWrite  = RegW & CondEx;
  assign MemWrite  = MemW & CondEx;
  assign ITActive  = (state == ACTIVE);
  assign flagw_req = FlagW & {FLAG_GROUPS{CondEx}};

  // AL/NV cannot open an IT block, and the length must be in 1..MAX_IT.
  assign it_start_ok = ITStart && (ITCond[3:1] != 3'b111) &&
                       (ITLen != '0) && (ITLen <= LENW'(MAX_IT));

  generate
    if (FLAGW_DELAY == 0) begin : g_nopipe
      assign flag_load = flagw_req;
    end else begin : g_pipe
      logic [FLAG_GROUPS-1:0] flagw_p [FLAGW_DELAY];

      // Delay the gated flag-write request; reset drops anything in flight.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < FLAGW_DELAY; i++) flagw_p[i] <= '0;
        end else begin
          flagw_p[0] <= flagw_req;
          for (int i = 1; i < FLAGW_DELAY; i++) flagw_p[i] <= flagw_p[i-1];
        end
      end

      assign flag_load = flagw_p[FLAGW_DELAY-1];
    end
  endgenerate

  // Load each flag group from the ALU when its delayed write strobe arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (flag_load[b / GW]) Flags[b] <= ALUFlags[b];
      end
    end
  end

  // IT sequencer: latch the block on a legal start, step one slot per retired instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      it_idx   <= '0;
      itcond_q <= '0;
      itmask_q <= '0;
      itlen_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (it_start_ok) begin
            state    <= ACTIVE;
            itcond_q <= ITCond;
            itmask_q <= ITMask | MAX_IT'(1);
            itlen_q  <= ITLen;
            it_idx   <= '0;
          end
        end
        ACTIVE: begin
          if (InstrDone) begin
            if (it_idx == itlen_q - LENW'(1)) begin
              state  <= IDLE;
              it_idx <= '0;
            end else begin
              it_idx <= it_idx + LENW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
